// File: rtl/reel_stop_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reel_stop_scheduler_pkg
// Description : Shared constants, state encoding and sizing helper for the
//               reel stop scheduler and its top-level integration.
// Revision    : 1.0 - initial release
// ============================================================================
package reel_stop_scheduler_pkg;

   localparam int N_REELS_DEFAULT      = 7;
   localparam int BLINK_CYCLES_DEFAULT = 6;
   localparam int TIMEOUT_DEFAULT      = 20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLINK = 2'd1,
      ST_SPIN  = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   // Bits needed to hold any value in 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      if (max_val < 2) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reel_stop_timer.sv
`default_nettype none
// ============================================================================
// Module      : reel_stop_timer
// Description : Idle-time counter for the reel currently allowed to stop.
//               Counts while enabled, saturates at TIMEOUT-1 and flags expiry
//               there; clr has priority and returns it to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reel_stop_timer
   import reel_stop_scheduler_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk_2,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            TW   = cnt_width(TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count;

   // Saturating count of cycles since the last clear; never wraps.
   always_ff @(posedge clk_2 or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/reel_stop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : reel_stop_scheduler
// Description : Round controller for the reel display: startup blink, then
//               reels stop strictly from the highest index down to reel 0,
//               either on request or automatically after an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module reel_stop_scheduler
   import reel_stop_scheduler_pkg::*;
#(
   parameter int N_REELS      = N_REELS_DEFAULT,
   parameter int BLINK_CYCLES = BLINK_CYCLES_DEFAULT,
   parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
   input  logic                                clk_2,
   input  logic                                rst,
   input  logic                                start,
   input  logic [N_REELS-1:0]                  stop_req,
   output logic [N_REELS-1:0]                  run_flag,
   output logic                                blink,
   output logic [1:0]                          state,
   output logic [cnt_width(N_REELS-1)-1:0]     next_idx,
   output logic                                done,
   output logic                                auto_stop
);

   localparam int               IDX_W     = cnt_width(N_REELS - 1);
   localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N_REELS - 1);
   localparam int               BW        = cnt_width(BLINK_CYCLES - 1);
   localparam logic [BW-1:0]    BLINK_END = BW'(BLINK_CYCLES - 1);

   sched_state_t       state_q, state_d;
   logic [BW-1:0]      bcnt_q, bcnt_d;
   logic [N_REELS-1:0] run_flag_d;
   logic [IDX_W-1:0]   next_idx_d;
   logic               blink_d;
   logic               done_d;
   logic               auto_stop_d;
   logic               valid_stop;
   logic               timer_clr;
   logic               timer_en;
   logic               timer_expire;

   reel_stop_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk_2  (clk_2),
      .rst    (rst),
      .clr    (timer_clr),
      .en     (timer_en),
      .expire (timer_expire)
   );

   // State and output registers; reset abandons any round in progress.
   always_ff @(posedge clk_2 or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bcnt_q    <= '0;
         run_flag  <= '0;
         blink     <= 1'b0;
         next_idx  <= IDX_TOP;
         done      <= 1'b0;
         auto_stop <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         run_flag  <= run_flag_d;
         blink     <= blink_d;
         next_idx  <= next_idx_d;
         done      <= done_d;
         auto_stop <= auto_stop_d;
      end
   end

   // Next-state and next-output decisions; the timer is held clear outside SPIN.
   always_comb begin
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      run_flag_d  = run_flag;
      blink_d     = blink;
      next_idx_d  = next_idx;
      done_d      = done;
      auto_stop_d = 1'b0;
      valid_stop  = 1'b0;
      timer_clr   = 1'b1;
      timer_en    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_BLINK;
               bcnt_d     = '0;
               blink_d    = 1'b1;
               done_d     = 1'b0;
               run_flag_d = '0;
            end
         end

         ST_BLINK: begin
            if (bcnt_q == BLINK_END) begin
               state_d    = ST_SPIN;
               run_flag_d = '1;
               blink_d    = 1'b0;
               next_idx_d = IDX_TOP;
            end else begin
               bcnt_d  = bcnt_q + 1'b1;
               blink_d = ~blink;
            end
         end

         ST_SPIN: begin
            timer_en   = 1'b1;
            timer_clr  = 1'b0;
            // Only the reel at next_idx may stop; a request there beats a timeout.
            valid_stop = stop_req[next_idx];
            if (valid_stop || timer_expire) begin
               timer_clr              = 1'b1;
               auto_stop_d            = ~valid_stop;
               run_flag_d[next_idx]   = 1'b0;
               if (next_idx == '0) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  run_flag_d = '0;
               end else begin
                  next_idx_d = next_idx - 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reel_stop_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_reel_stop_scheduler
// Description : Directed scenarios followed by randomized rounds, compared
//               against a round-level behavioural model of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reel_stop_scheduler;

   localparam int NR = 7;
   localparam int BC = 6;
   localparam int TO = 20;

   logic          clk_2 = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic [NR-1:0] stop_req = '0;
   logic [NR-1:0] run_flag;
   logic          blink;
   logic [1:0]    state;
   logic [2:0]    next_idx;
   logic          done;
   logic          auto_stop;

   reel_stop_scheduler #(
      .N_REELS      (NR),
      .BLINK_CYCLES (BC),
      .TIMEOUT      (TO)
   ) dut (
      .clk_2     (clk_2),
      .rst       (rst),
      .start     (start),
      .stop_req  (stop_req),
      .run_flag  (run_flag),
      .blink     (blink),
      .state     (state),
      .next_idx  (next_idx),
      .done      (done),
      .auto_stop (auto_stop)
   );

   always #5 clk_2 = ~clk_2;

   int tests = 0;
   int fails = 0;

   // Round model: phase 0 idle, 1 blink, 2 spin, 3 done.
   int m_phase, m_bpos, m_stopped, m_quiet;
   bit m_auto;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_phase   = 0;
      m_bpos    = 0;
      m_stopped = 0;
      m_quiet   = 0;
      m_auto    = 0;
   endtask

   task automatic check_model(input string where);
      int want_run, want_idx;
      want_run = (m_phase == 2) ? ((1 << (NR - m_stopped)) - 1) : 0;
      want_idx = (m_phase == 3) ? 0 : ((m_phase == 2) ? (NR - 1 - m_stopped) : NR - 1);
      chk({where, " state"},    32'(state),     32'(m_phase));
      chk({where, " blink"},    32'(blink),     32'((m_phase == 1) && (m_bpos % 2 == 0)));
      chk({where, " run_flag"}, 32'(run_flag),  32'(want_run));
      if (m_phase != 1)
         chk({where, " next_idx"}, 32'(next_idx), 32'(want_idx));
      chk({where, " done"},      32'(done),      32'(m_phase == 3));
      chk({where, " auto_stop"}, 32'(auto_stop), 32'(m_auto));
   endtask

   // Apply inputs for one edge, advance the model, then check after the edge.
   task automatic step(input logic s, input logic [NR-1:0] sr, input string where);
      int  idx;
      bit  valid;
      start    = s;
      stop_req = sr;
      m_auto   = 0;
      case (m_phase)
         0, 3: if (s) begin m_phase = 1; m_bpos = 0; end
         1: begin
            if (m_bpos == BC - 1) begin
               m_phase = 2; m_stopped = 0; m_quiet = 0;
            end else begin
               m_bpos++;
            end
         end
         default: begin
            idx   = NR - 1 - m_stopped;
            valid = sr[idx];
            if (valid || (m_quiet == TO - 1)) begin
               m_stopped++;
               m_quiet = 0;
               m_auto  = !valid;
               if (m_stopped == NR) m_phase = 3;
            end else begin
               m_quiet++;
            end
         end
      endcase
      @(posedge clk_2);
      #1;
      check_model(where);
   endtask

   // Assert reset between edges and confirm outputs fall before the next edge.
   task automatic mid_reset(input string where);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_model(where);
      #2;
      rst = 1'b0;
   endtask

   task automatic blink_phase();
      step(1'b1, 7'h00, "start");
      for (int i = 0; i < BC; i++) step(1'b1, 7'($urandom), "blink");
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #2 check_model("reset");
      #5 rst = 1'b0;

      step(1'b0, 7'h7F, "idle");
      step(1'b0, 7'h00, "idle");

      // Startup: blink pattern then all reels spinning.
      blink_phase();
      chk("spin entry run_flag", 32'(run_flag), 32'h7F);
      chk("spin entry next_idx", 32'(next_idx), 32'd6);

      // Ordered manual stops.
      step(1'b0, 7'h40, "stop6");
      chk("stop6 run_flag", 32'(run_flag), 32'h3F);
      step(1'b1, 7'h20, "stop5");
      chk("stop5 run_flag", 32'(run_flag), 32'h1F);
      step(1'b0, 7'h10, "stop4");
      chk("stop4 run_flag", 32'(run_flag), 32'h0F);
      chk("stop4 auto_stop", 32'(auto_stop), 32'd0);
      step(1'b0, 7'h08, "stop3");
      step(1'b0, 7'h04, "stop2");
      step(1'b0, 7'h02, "stop1");
      step(1'b0, 7'h01, "stop0");
      chk("round done", 32'(done), 32'd1);
      chk("round done run_flag", 32'(run_flag), 32'h00);
      step(1'b0, 7'h7F, "done hold");

      // Restart from DONE, then out-of-order request and timeout.
      blink_phase();
      step(1'b0, 7'h01, "out of order");
      chk("out of order run_flag", 32'(run_flag), 32'h7F);
      for (int i = 0; i < TO - 1; i++) step(1'b0, 7'h00, "wait timeout");
      chk("timeout auto_stop", 32'(auto_stop), 32'd1);
      chk("timeout run_flag", 32'(run_flag), 32'h3F);

      // Valid request landing exactly on the timeout cycle.
      for (int i = 0; i < TO - 1; i++) step(1'b0, 7'h00, "wait coincide");
      step(1'b0, 7'h20, "coincide");
      chk("coincide auto_stop", 32'(auto_stop), 32'd0);
      chk("coincide run_flag", 32'(run_flag), 32'h1F);

      // Asynchronous abort mid-spin.
      mid_reset("abort");
      chk("abort run_flag", 32'(run_flag), 32'h00);

      // Timer restarts from zero after a manual stop.
      blink_phase();
      step(1'b0, 7'h40, "restart stop6");
      for (int i = 0; i < TO - 1; i++) step(1'b0, 7'h00, "quiet");
      chk("no early auto_stop", 32'(run_flag), 32'h3F);
      step(1'b0, 7'h00, "late timeout");
      chk("late auto_stop", 32'(auto_stop), 32'd1);

      // Randomized operation.
      for (int n = 0; n < 1500; n++) begin
         int          r;
         logic [NR-1:0] sr;
         r = $urandom_range(0, 11);
         if (r == 0 && m_phase == 2)
            sr = 7'(1 << (NR - 1 - m_stopped));
         else if (r <= 1)
            sr = 7'($urandom);
         else
            sr = 7'h00;
         if ($urandom_range(0, 299) == 0)
            mid_reset("random abort");
         else
            step(($urandom_range(0, 3) == 0), sr, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
